// File: rtl/data_memory_responder_pkg.sv
// Shared constants and types for the data memory responder.
package data_memory_responder_pkg;

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Latency counter width; supports LATENCY up to 15
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte enables for a store of the given width at the given byte lane
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// Word-organised storage with per-byte write enables and a registered read.
module data_memory_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-enabled write and read of the same index; the read returns the pre-write contents
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder: one request in flight, response after LATENCY cycles.
//
// state | meaning
// IDLE  | ready for a request; capture it on handshake
// BUSY  | counting down latency; access memory when counter reaches 0
// RESP  | response held on outputs until the requester takes it
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t                state_q, state_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic                  accept;
  logic                  commit;

  logic                  cap_write;
  logic [2:0]            cap_funct3;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [31:0]           cap_wdata;

  logic [1:0]            lane;
  logic                  f3_ok;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  err;

  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [IDX_W-1:0]      mem_idx;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_data;

  // Next state, latency countdown and handshake outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = ~reset;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = LAT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture; inputs are free to change once accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_write  <= 1'b0;
      cap_funct3 <= 3'b000;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else if (accept) begin
      cap_write  <= req_write;
      cap_funct3 <= req_funct3;
      cap_addr   <= req_addr;
      cap_wdata  <= req_wdata;
    end
  end

  assign lane = cap_addr[1:0];

  // Error decode on the captured request
  always_comb begin
    f3_ok = 1'b0;
    case (cap_funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = ~cap_write;
      default:          f3_ok = 1'b0;
    endcase
    misaligned   = (((cap_funct3 == F3_H) || (cap_funct3 == F3_HU)) && cap_addr[0]) ||
                   ((cap_funct3 == F3_W) && (cap_addr[1:0] != 2'b00));
    out_of_range = {2'b00, cap_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH_WORDS);
    err          = ~f3_ok | misaligned | out_of_range;
  end

  // Store lane placement: replicate the right-aligned data so every lane sees it
  always_comb begin
    mem_wdata = cap_wdata;
    case (cap_funct3)
      F3_B:    mem_wdata = {4{cap_wdata[7:0]}};
      F3_H:    mem_wdata = {2{cap_wdata[15:0]}};
      default: mem_wdata = cap_wdata;
    endcase
  end

  // Read is launched from the live request in IDLE so data is ready even for LATENCY=1
  assign mem_idx = (state_q == IDLE) ? req_addr[IDX_W+1:2] : cap_addr[IDX_W+1:2];
  assign mem_be  = store_be(cap_funct3, lane);
  assign mem_we  = commit & cap_write & ~err & ~reset;

  data_memory_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Load lane extraction and sign/zero extension
  always_comb begin
    byte_sel  = mem_rdata[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = 32'h0;
    case (cap_funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = mem_rdata;
      default: load_data = 32'h0;
    endcase
  end

  // Response registers: loaded at the commit edge, cleared once the response is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
    end else if (commit) begin
      resp_error <= err;
      resp_rdata <= (err || cap_write) ? 32'h0 : load_data;
    end else if (resp_valid && resp_ready) begin
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
    end
  end

endmodule
